dcache_controller: RTL and testbench

- Responder for the pipeline's MEM-stage load/store port; replaces the single-cycle data memory with a direct-mapped, write-back, write-allocate data cache.
- Answers hits in the same cycle. On a miss it holds `p1_stall_o` high, then runs a write-back and/or line-fill handshake with off-chip memory.
- The pipeline freezes while `p1_stall_o` is high.

---
 rtl/dcache_pkg.sv | 31 +++
 rtl/dcache_sram.sv | 65 ++++++
 rtl/dcache_controller.sv | 156 +++++++++++++++
 tb/tb_dcache_controller.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcache_pkg
// Brief    : Shared types, field geometry and address helpers for the
//            direct-mapped write-back data cache.
// Revision : 1.0 - initial release
// ============================================================================
package dcache_pkg;

    localparam int OFFSET_W   = 5;
    localparam int WORD_MSB   = 4;
    localparam int WORD_LSB   = 2;
    localparam int MAX_ADDR_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } state_t;

    // Block-aligned address {tag, index, zero offset}, zero-extended to MAX_ADDR_W.
    function automatic logic [MAX_ADDR_W-1:0] block_addr(
        input logic [MAX_ADDR_W-1:0] tag,
        input logic [MAX_ADDR_W-1:0] index,
        input int                    index_w
    );
        return (tag << (OFFSET_W + index_w)) | (index << OFFSET_W);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_sram.sv
`default_nettype none
// ============================================================================
// Module   : dcache_sram
// Brief    : Tag/valid/dirty and data arrays; asynchronous read, one
//            synchronous write port (full-line fill or single-word merge).
// Revision : 1.0 - initial release
// ============================================================================
module dcache_sram #(
    parameter int LINES   = 32,
    parameter int INDEX_W = 5,
    parameter int TAG_W   = 22,
    parameter int BLOCK_W = 256,
    parameter int WSEL_W  = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [INDEX_W-1:0]  index,
    output logic                rd_valid,
    output logic                rd_dirty,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [BLOCK_W-1:0]  rd_line,
    input  logic                wr_en,
    input  logic                wr_full,
    input  logic [WSEL_W-1:0]   wr_word_sel,
    input  logic [31:0]         wr_word,
    input  logic [TAG_W-1:0]    wr_tag,
    input  logic [BLOCK_W-1:0]  wr_line
);

    logic [BLOCK_W-1:0] r_data [LINES];
    logic [TAG_W-1:0]   r_tag  [LINES];
    logic [LINES-1:0]   r_valid;
    logic [LINES-1:0]   r_dirty;

    assign rd_valid = r_valid[index];
    assign rd_dirty = r_dirty[index];
    assign rd_tag   = r_tag[index];
    assign rd_line  = r_data[index];

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            if (wr_full) begin
                r_data[index] <= wr_line;
                r_tag[index]  <= wr_tag;
            end else begin
                r_data[index][{wr_word_sel, 5'd0} +: 32] <= wr_word;
            end
        end
    end

    // A fill leaves the line clean; a word merge marks it dirty.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (wr_en) begin
            if (wr_full) begin
                r_valid[index] <= 1'b1;
            end
            r_dirty[index] <= ~wr_full;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
// Module   : dcache_controller
// Brief    : Direct-mapped, write-back, write-allocate data cache in front of
//            the MEM-stage port; hits answer in-cycle, misses stall the CPU.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int LINES   = 32,
    parameter int BLOCK_W = 256,
    parameter int ADDR_W  = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [ADDR_W-1:0]  p1_addr_i,
    input  logic [31:0]        p1_data_i,
    input  logic               p1_MemRead_i,
    input  logic               p1_MemWrite_i,
    output logic [31:0]        p1_data_o,
    output logic               p1_stall_o,
    output logic               mem_enable_o,
    output logic               mem_write_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic [BLOCK_W-1:0] mem_data_o,
    input  logic [BLOCK_W-1:0] mem_data_i,
    input  logic               mem_ack_i
);

    localparam int INDEX_W = $clog2(LINES);
    localparam int TAG_W   = ADDR_W - OFFSET_W - INDEX_W;
    localparam int WSEL_W  = WORD_MSB - WORD_LSB + 1;

    state_t r_state;
    state_t w_next_state;
    logic   r_mem_enable;
    logic   r_mem_write;

    logic [INDEX_W-1:0]    w_index;
    logic [TAG_W-1:0]      w_req_tag;
    logic [WSEL_W-1:0]     w_word_sel;
    logic                  w_req;
    logic                  w_store;
    logic                  w_hit;
    logic                  w_valid;
    logic                  w_dirty;
    logic [TAG_W-1:0]      w_tag;
    logic [BLOCK_W-1:0]    w_line;
    logic [31:0]           w_sel_word;
    logic                  w_wr_req;
    logic                  w_wr_full;
    logic                  w_wr_en;
    logic [MAX_ADDR_W-1:0] w_victim_addr;
    logic [MAX_ADDR_W-1:0] w_fill_addr;
    logic                  w_unused;

    assign w_index    = p1_addr_i[OFFSET_W +: INDEX_W];
    assign w_req_tag  = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign w_word_sel = p1_addr_i[WORD_MSB:WORD_LSB];
    assign w_req      = p1_MemRead_i | p1_MemWrite_i;
    assign w_store    = p1_MemWrite_i;
    assign w_hit      = w_valid && (w_tag == w_req_tag);
    assign w_sel_word = w_line[{w_word_sel, 5'd0} +: 32];

    // Reset takes priority over a coincident fill so no line is touched.
    assign w_wr_en    = w_wr_req & ~rst_i;

    dcache_sram #(
        .LINES   (LINES),
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .BLOCK_W (BLOCK_W),
        .WSEL_W  (WSEL_W)
    ) u_sram (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .index       (w_index),
        .rd_valid    (w_valid),
        .rd_dirty    (w_dirty),
        .rd_tag      (w_tag),
        .rd_line     (w_line),
        .wr_en       (w_wr_en),
        .wr_full     (w_wr_full),
        .wr_word_sel (w_word_sel),
        .wr_word     (p1_data_i),
        .wr_tag      (w_req_tag),
        .wr_line     (mem_data_i)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_mem_enable <= 1'b0;
            r_mem_write  <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_mem_enable <= (w_next_state != ST_IDLE);
            r_mem_write  <= (w_next_state == ST_WRITEBACK);
        end
    end

    always_comb begin
        w_next_state = r_state;
        p1_stall_o   = 1'b0;
        p1_data_o    = '0;
        w_wr_req     = 1'b0;
        w_wr_full    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (w_hit) begin
                        if (w_store) begin
                            w_wr_req = 1'b1;
                        end else begin
                            p1_data_o = w_sel_word;
                        end
                    end else begin
                        p1_stall_o   = 1'b1;
                        w_next_state = (w_valid && w_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
                    end
                end
            end
            ST_WRITEBACK: begin
                p1_stall_o = 1'b1;
                if (mem_ack_i) begin
                    w_next_state = ST_ALLOCATE;
                end
            end
            ST_ALLOCATE: begin
                p1_stall_o = 1'b1;
                if (mem_ack_i) begin
                    w_wr_req     = 1'b1;
                    w_wr_full    = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_victim_addr = block_addr(MAX_ADDR_W'(w_tag), MAX_ADDR_W'(w_index), INDEX_W);
    assign w_fill_addr   = block_addr(MAX_ADDR_W'(w_req_tag), MAX_ADDR_W'(w_index), INDEX_W);

    assign mem_enable_o = r_mem_enable;
    assign mem_write_o  = r_mem_write;
    assign mem_addr_o   = r_mem_write ? w_victim_addr[ADDR_W-1:0] : w_fill_addr[ADDR_W-1:0];
    assign mem_data_o   = w_line;

    assign w_unused = &{1'b0, p1_addr_i[WORD_LSB-1:0],
                        w_victim_addr[MAX_ADDR_W-1:ADDR_W], w_fill_addr[MAX_ADDR_W-1:ADDR_W]};

endmodule
`default_nettype wire

// File: tb/tb_dcache_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_controller
// Brief    : Self-checking bench: directed scenarios plus random traffic
//            against a flat-memory / cache-occupancy reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_controller;

    logic         clk;
    logic         rst;
    logic [31:0]  p1_addr;
    logic [31:0]  p1_wdata;
    logic         p1_rd;
    logic         p1_wr;
    logic [31:0]  p1_rdata;
    logic         p1_stall;
    logic         mem_en;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_ack;

    logic         resp_ack;
    logic [255:0] resp_data;
    logic         man_ack;
    logic [255:0] man_data;
    bit           resp_on;
    int           fixed_delay;

    assign mem_ack   = resp_ack | man_ack;
    assign mem_rdata = man_ack ? man_data : resp_data;

    dcache_controller dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .p1_addr_i     (p1_addr),
        .p1_data_i     (p1_wdata),
        .p1_MemRead_i  (p1_rd),
        .p1_MemWrite_i (p1_wr),
        .p1_data_o     (p1_rdata),
        .p1_stall_o    (p1_stall),
        .mem_enable_o  (mem_en),
        .mem_write_o   (mem_we),
        .mem_addr_o    (mem_addr),
        .mem_data_o    (mem_wdata),
        .mem_data_i    (mem_rdata),
        .mem_ack_i     (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: off-chip memory by block, CPU-visible memory by word,
    // and which block each cache index currently holds.
    logic [255:0] backing [logic [31:0]];
    logic [31:0]  gold    [logic [31:0]];
    bit           m_valid [32];
    bit           m_dirty [32];
    logic [21:0]  m_tag   [32];
    logic [255:0] last_wb_data;
    int           last_alloc_cycles;

    function automatic logic [31:0] pat(input logic [31:0] wa);
        return {wa[15:0], ~wa[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [255:0] get_block(input logic [31:0] ba);
        logic [255:0] b;
        if (backing.exists(ba)) return backing[ba];
        for (int w = 0; w < 8; w++) b[w*32 +: 32] = pat(ba + 32'(w * 4));
        return b;
    endfunction

    function automatic logic [31:0] gold_word(input logic [31:0] wa);
        if (gold.exists(wa)) return gold[wa];
        return pat(wa);
    endfunction

    function automatic logic [255:0] gold_block(input logic [31:0] ba);
        logic [255:0] b;
        for (int w = 0; w < 8; w++) b[w*32 +: 32] = gold_word(ba + 32'(w * 4));
        return b;
    endfunction

    task automatic set_mem_word(input logic [31:0] wa, input logic [31:0] val);
        logic [255:0] b;
        b = get_block({wa[31:5], 5'b0});
        b[wa[4:2]*32 +: 32] = val;
        backing[{wa[31:5], 5'b0}] = b;
        gold[{wa[31:2], 2'b0}] = val;
    endtask

    // Reset discards dirty data: the CPU-visible view falls back to memory.
    task automatic model_reset();
        logic [255:0] b;
        logic [31:0]  ba;
        for (int i = 0; i < 32; i++) begin
            if (m_valid[i] && m_dirty[i]) begin
                ba = {m_tag[i], 5'(i), 5'b0};
                b  = get_block(ba);
                for (int w = 0; w < 8; w++) gold[ba + 32'(w * 4)] = b[w*32 +: 32];
            end
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    // Off-chip memory: acks each request after a fixed or random wait.
    initial begin : resp_proc
        bit          busy;
        int          cnt;
        logic [31:0] r_addr;
        bit          r_write;
        resp_ack  = 1'b0;
        resp_data = '0;
        busy      = 1'b0;
        cnt       = 0;
        r_addr    = '0;
        r_write   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_ack) begin
                resp_ack = 1'b0;
                busy     = 1'b0;
            end
            if (rst) busy = 1'b0;
            if (!busy && resp_on && mem_en) begin
                busy    = 1'b1;
                r_addr  = mem_addr;
                r_write = mem_we;
                cnt     = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
                if (mem_we) backing[mem_addr] = mem_wdata;
            end
            if (busy) begin
                if (cnt == 0) begin
                    resp_ack = 1'b1;
                    if (!r_write) resp_data = get_block(r_addr);
                end else begin
                    cnt--;
                end
            end
        end
    end

    task automatic access(input logic [31:0] addr, input bit st, input bit both, input logic [31:0] wdata);
        logic [4:0]   idx;
        logic [21:0]  tg;
        logic [31:0]  ba;
        logic [31:0]  wa;
        logic [31:0]  wb_addr;
        logic [255:0] wb_exp;
        logic [31:0]  got_wb_addr;
        logic [31:0]  al_addr;
        bit           exp_hit;
        bit           exp_wb;
        bit           saw_wb;
        bit           saw_alloc;
        int           cyc;
        int           holdbad;
        int           d;
        idx     = addr[9:5];
        tg      = addr[31:10];
        ba      = {addr[31:5], 5'b0};
        wa      = {addr[31:2], 2'b0};
        exp_hit = m_valid[idx] && (m_tag[idx] == tg);
        exp_wb  = !exp_hit && m_valid[idx] && m_dirty[idx];
        wb_addr = {m_tag[idx], idx, 5'b0};
        wb_exp  = gold_block(wb_addr);
        d       = fixed_delay;
        saw_wb = 0; saw_alloc = 0; cyc = 0; holdbad = 0;
        got_wb_addr = '0; al_addr = '0; last_alloc_cycles = 0;

        @(negedge clk);
        p1_addr  = addr;
        p1_wdata = wdata;
        p1_wr    = st;
        p1_rd    = !st || both;
        #1;
        check("stall_detect", p1_stall, !exp_hit);
        if (exp_hit) check("hit_no_req", mem_en, 0);
        while (p1_stall && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            if (mem_en && mem_we && !saw_wb) begin
                saw_wb       = 1;
                got_wb_addr  = mem_addr;
                last_wb_data = mem_wdata;
            end
            if (mem_en && !mem_we) begin
                last_alloc_cycles++;
                if (!saw_alloc) begin
                    saw_alloc = 1;
                    al_addr   = mem_addr;
                end else if (mem_addr !== al_addr || p1_stall !== 1'b1) begin
                    holdbad++;
                end
            end
        end
        check("stall_release", p1_stall, 0);
        if (!exp_hit) begin
            check("wb_seen", saw_wb, exp_wb);
            if (exp_wb) begin
                check("wb_addr", got_wb_addr, wb_addr);
                check("wb_data", last_wb_data, wb_exp);
            end
            check("alloc_addr", al_addr, ba);
            check("alloc_hold", holdbad, 0);
            check("idle_no_req", mem_en, 0);
            if (d >= 0) check("miss_latency", cyc, 1 + (exp_wb ? d + 1 : 0) + d + 1);
        end
        if (!st) check("load_data", p1_rdata, gold_word(wa));

        if (!exp_hit) begin
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
        end
        if (st) begin
            m_dirty[idx] = 1'b1;
            gold[wa]     = wdata;
        end
        @(posedge clk);
        #1;
        p1_rd = 1'b0;
        p1_wr = 1'b0;
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        logic [31:0] a;
        int          waited;
        rst = 1'b1; p1_addr = '0; p1_wdata = '0; p1_rd = 1'b0; p1_wr = 1'b0;
        man_ack = 1'b0; man_data = '0; resp_on = 1'b1; fixed_delay = 10;
        last_wb_data = '0; last_alloc_cycles = 0;
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = '0;
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_enable", mem_en, 0);
        check("rst_write", mem_we, 0);
        check("rst_stall", p1_stall, 0);
        check("rst_data", p1_rdata, 0);
        @(negedge clk);
        rst = 1'b0;

        // Fill, hit re-read, store hit, dirty eviction, clean eviction.
        set_mem_word(32'h48, 32'hDEAD_BEEF);
        access(32'h40, 0, 0, '0);
        access(32'h48, 0, 0, '0);
        access(32'h44, 1, 0, 32'h1234_5678);
        access(32'h44, 0, 0, '0);
        fixed_delay = 3;
        access(32'h440, 0, 0, '0);
        check("wb_word1", last_wb_data[63:32], 32'h1234_5678);
        access(32'h840, 0, 0, '0);

        // Long fill wait: outputs must stay put the whole time.
        fixed_delay = 55;
        access(32'hC40, 0, 0, '0);
        check("alloc_wait_len", (last_alloc_cycles >= 50), 1);
        fixed_delay = -1;

        // Spurious ack while idle.
        @(negedge clk);
        man_data = {8{32'hBAD0_BAD0}};
        man_ack  = 1'b1;
        @(posedge clk);
        #1;
        check("spur_enable", mem_en, 0);
        check("spur_stall", p1_stall, 0);
        @(negedge clk);
        man_ack = 1'b0;
        access(32'hC48, 0, 0, '0);

        // Reset mid-fill, coincident with an ack, then a late ack.
        resp_on = 1'b0;
        a = 32'h1060;
        @(negedge clk);
        p1_addr = a; p1_rd = 1'b1; p1_wr = 1'b0;
        waited = 0;
        while (!(mem_en && !mem_we) && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("rst_alloc_seen", (mem_en && !mem_we), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; man_ack = 1'b1; p1_rd = 1'b0;
        @(posedge clk);
        #1;
        check("rstmid_enable", mem_en, 0);
        check("rstmid_write", mem_we, 0);
        check("rstmid_stall", p1_stall, 0);
        check("rstmid_data", p1_rdata, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("late_ack_enable", mem_en, 0);
        @(negedge clk);
        man_ack = 1'b0;
        model_reset();
        resp_on = 1'b1;
        access(a, 0, 0, '0);
        access(32'h44, 0, 0, '0);

        // Random traffic over a few indexes and tags to force conflicts.
        for (int n = 0; n < 300; n++) begin
            a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 5)
              | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            access(a, ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0), $urandom);
            if ($urandom_range(0, 3) == 0) @(posedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
